reg_apb_mst_bridge: RTL and testbench
=====================================

// Module: reg_apb_mst_bridge
// PURPOSE
//  Upstream master stage for slv_fsm: converts an APB4 completer port into the native
//  register request interface (mst__fsm__*) and returns fsm__mst__* acks as APB responses.
//  Issues one single-cycle request per APB transfer; a watchdog aborts hung accesses by
//  pulsing mst__fsm__sync_reset and answering PSLVERR. Sits between the SoC APB fabric and slv_fsm.
// PARAMETERS
//  ADDR_WIDTH   64  address width, PADDR and mst__fsm__addr
//  DATA_WIDTH   32  data width, PWDATA/PRDATA and native data
//  TIMEOUT_CYC  255 max cycles in S_WAIT_ACK before abort; 0 = watchdog disabled
// PORTS
//  clk                  in  1    clock
//  rstn                 in  1    async reset, active-low
//  psel                 in  1    APB select
//  penable              in  1    APB enable (access phase)
//  pwrite               in  1    APB write=1 / read=0
//  paddr                in  AW   APB address
//  pwdata               in  DW   APB write data
//  pready               out 1    APB ready (registered)
//  prdata               out DW   APB read data (registered)
//  pslverr              out 1    APB error (registered)
//  soft_rst             in  1    software abort request, level
//  mst__fsm__req_vld    out 1    native request, single-cycle pulse
//  mst__fsm__rd_en      out 1    read enable, valid with req_vld
//  mst__fsm__wr_en      out 1    write enable, valid with req_vld
//  mst__fsm__addr       out AW   address, valid with req_vld
//  mst__fsm__wr_data    out DW   write data, valid with req_vld
//  mst__fsm__sync_reset out 1    sync abort to slv_fsm
//  fsm__mst__ack_vld    in  1    native ack, single cycle
//  fsm__mst__rd_data    in  DW   read data, valid only with ack_vld
//  timeout_evt          out 1    one-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset: state=S_IDLE; all outputs 0; watchdog count 0.
//  FSM (registered):
//   S_IDLE  : psel & !penable (setup) -> latch pwrite/paddr/pwdata -> S_REQ.
//   S_REQ   : req_vld=1, rd_en=!wr, wr_en=wr, addr/wr_data from latches (0 in other states).
//             ack this cycle -> S_DONE; else -> S_WAIT_ACK, count cleared.
//   S_WAIT_ACK: req_vld=0; count+1 per cycle; ack -> S_DONE (OK);
//             count==TIMEOUT_CYC-1 w/o ack (TIMEOUT_CYC!=0) -> S_DONE (ERR), sync_reset=1 and
//             timeout_evt=1 for exactly the transition cycle.
//   S_DONE  : pready=1 one cycle; prdata=captured data (reads OK only, else 0); pslverr=ERR flag;
//             -> S_IDLE unconditionally.
//  Min latency: setup at cycle T, req_vld at T+1, pready at T+2 when ack same cycle as req.
//  pready/pslverr/prdata are 0 outside S_DONE.
//  Ack captured with read data in the cycle it arrives; acks in S_IDLE/S_DONE ignored.
//  Ack and timeout in the same cycle: ack wins, no error, no sync_reset.
//  soft_rst: mst__fsm__sync_reset = soft_rst | timeout pulse (combinational OR of registered terms).
//   soft_rst in S_REQ/S_WAIT_ACK -> S_DONE with ERR; in S_IDLE new setups are held off until low.
//  psel dropped mid-transfer (protocol violation): internal transfer still completes to S_DONE.
//  Writes: prdata=0. Count width $clog2(TIMEOUT_CYC+1), saturates, never wraps.
//  rstn mid-transfer: immediate return to reset values; no response issued.
// STRUCTURE
//  Package reg_native_pkg: state enum {S_IDLE,S_REQ,S_WAIT_ACK,S_DONE}, resp enum {RESP_OK,RESP_ERR}.
//  Sub-module reg_watchdog_cnt (clear, enable, expire pulse; param TIMEOUT_CYC).
// TESTING
//  Read, ack same cycle as req, rd_data=32'hDEAD_BEEF -> pready at T+2, prdata=DEADBEEF, pslverr=0.
//  Write addr=64'h40 data=32'h1234 ack 5 cycles late -> one req_vld pulse, wr_en=1, pready once.
//  TIMEOUT_CYC=4, no ack -> sync_reset+timeout_evt pulse after 4 cycles, pslverr=1, prdata=0.
//  Ack coincident with timeout cycle -> pslverr=0, no sync_reset.
//  soft_rst asserted in S_WAIT_ACK -> sync_reset high, pslverr=1; setup held off until soft_rst=0.
//  Back-to-back 10 random APB transfers vs slv_fsm model -> exactly 10 req_vld, data matches.

Source files
------------

// File: rtl/reg_native_pkg.sv
// Shared types for the native register request path: bridge FSM states
// and the completion response code returned toward the APB side.
package reg_native_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_ACK,
        S_DONE
    } state_e;

    typedef enum logic {
        RESP_OK,
        RESP_ERR
    } resp_e;

endpackage

// File: rtl/reg_watchdog_cnt.sv
// Saturating cycle counter used as the access watchdog.
// Ports: clk, rstn (async, active-low); clear_i zeroes the count,
// enable_i counts one per cycle; expire_o flags the last allowed cycle.
// TIMEOUT_CYC = 0 disables expiry entirely.
module reg_watchdog_cnt
    import reg_native_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CW =
        (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] SAT  = '1;
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (TIMEOUT_CYC != 0) && enable_i && (cnt_q == LAST);

endmodule

// File: rtl/reg_apb_mst_bridge.sv
// APB4 completer to native register request bridge with hang watchdog.
// Ports: APB (psel/penable/pwrite/paddr/pwdata -> pready/prdata/pslverr),
// native request mst__fsm__*, ack fsm__mst__*, soft_rst abort input,
// sync_reset abort output and timeout_evt watchdog pulse.
module reg_apb_mst_bridge
    import reg_native_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    input  logic                  soft_rst,
    output logic                  mst__fsm__req_vld,
    output logic                  mst__fsm__rd_en,
    output logic                  mst__fsm__wr_en,
    output logic [ADDR_WIDTH-1:0] mst__fsm__addr,
    output logic [DATA_WIDTH-1:0] mst__fsm__wr_data,
    output logic                  mst__fsm__sync_reset,
    input  logic                  fsm__mst__ack_vld,
    input  logic [DATA_WIDTH-1:0] fsm__mst__rd_data,
    output logic                  timeout_evt
);

    state_e                  state_q, state_d;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    lat_en, fin;
    resp_e                   resp;
    logic                    in_req, wd_clr, wd_en, wd_expire, tmo_pulse;

    assign in_req = (state_q == S_REQ);
    assign wd_clr = in_req;
    assign wd_en  = (state_q == S_WAIT_ACK);

    reg_watchdog_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .rstn    (rstn),
        .clear_i (wd_clr),
        .enable_i(wd_en),
        .expire_o(wd_expire)
    );

    // A watchdog abort only counts when neither an ack nor a software
    // abort already decided the outcome of this cycle.
    assign tmo_pulse = wd_expire && !fsm__mst__ack_vld && !soft_rst;

    always_comb begin
        state_d   = state_q;
        lat_en    = 1'b0;
        fin       = 1'b0;
        resp      = RESP_OK;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (psel && !penable && !soft_rst) begin
                    lat_en  = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (soft_rst) begin
                    fin  = 1'b1;
                    resp = RESP_ERR;
                end else if (fsm__mst__ack_vld) begin
                    fin = 1'b1;
                end else begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (soft_rst) begin
                    fin  = 1'b1;
                    resp = RESP_ERR;
                end else if (fsm__mst__ack_vld) begin
                    fin = 1'b1;
                end else if (wd_expire) begin
                    fin  = 1'b1;
                    resp = RESP_ERR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Response regs load on entry to S_DONE so they are high there only.
        if (fin) begin
            state_d   = S_DONE;
            pready_d  = 1'b1;
            pslverr_d = (resp == RESP_ERR);
            if ((resp == RESP_OK) && !wr_q) begin
                prdata_d = fsm__mst__rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            if (lat_en) begin
                wr_q    <= pwrite;
                addr_q  <= paddr;
                wdata_q <= pwdata;
            end
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;

    assign mst__fsm__req_vld    = in_req;
    assign mst__fsm__rd_en      = in_req && !wr_q;
    assign mst__fsm__wr_en      = in_req && wr_q;
    assign mst__fsm__addr       = in_req ? addr_q : '0;
    assign mst__fsm__wr_data    = in_req ? wdata_q : '0;
    assign mst__fsm__sync_reset = soft_rst || tmo_pulse;
    assign timeout_evt          = tmo_pulse;

endmodule

// File: tb/tb_reg_apb_mst_bridge.sv
// Directed bench for reg_apb_mst_bridge: instance a (TIMEOUT_CYC=16)
// for normal traffic, instance b (TIMEOUT_CYC=4) for watchdog cases.
module tb_reg_apb_mst_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        psel, penable, pwrite, soft_rst, ack, sel;
    logic [63:0] paddr;
    logic [31:0] pwdata, rd_data;

    logic        pready_a, pslverr_a, req_a, rd_a, wr_a, sr_a, to_a;
    logic        pready_b, pslverr_b, req_b, rd_b, wr_b, sr_b, to_b;
    logic [31:0] prdata_a, wd_a, prdata_b, wd_b;
    logic [63:0] addr_a, addr_b;

    logic        pready, pslverr, req_vld, rd_en, wr_en, sync_rst, tmo_evt;
    logic [31:0] prdata, mwdata;
    logic [63:0] maddr;

    int n_chk = 0;
    int n_fail = 0;

    int          nreq, nrdy, nsr, nto, rdy_cyc, sr_first, to_cyc;
    logic        rec_rd, rec_wr, rec_err, post_rdy;
    logic [63:0] rec_addr;
    logic [31:0] rec_wdata, rec_prdata;

    always #5 clk = ~clk;

    reg_apb_mst_bridge #(
        .ADDR_WIDTH(64), .DATA_WIDTH(32), .TIMEOUT_CYC(16)
    ) u_dut_a (
        .clk(clk), .rstn(rstn), .psel(psel && !sel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready_a), .prdata(prdata_a), .pslverr(pslverr_a),
        .soft_rst(soft_rst), .mst__fsm__req_vld(req_a),
        .mst__fsm__rd_en(rd_a), .mst__fsm__wr_en(wr_a),
        .mst__fsm__addr(addr_a), .mst__fsm__wr_data(wd_a),
        .mst__fsm__sync_reset(sr_a), .fsm__mst__ack_vld(ack),
        .fsm__mst__rd_data(rd_data), .timeout_evt(to_a)
    );

    reg_apb_mst_bridge #(
        .ADDR_WIDTH(64), .DATA_WIDTH(32), .TIMEOUT_CYC(4)
    ) u_dut_b (
        .clk(clk), .rstn(rstn), .psel(psel && sel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready_b), .prdata(prdata_b), .pslverr(pslverr_b),
        .soft_rst(soft_rst), .mst__fsm__req_vld(req_b),
        .mst__fsm__rd_en(rd_b), .mst__fsm__wr_en(wr_b),
        .mst__fsm__addr(addr_b), .mst__fsm__wr_data(wd_b),
        .mst__fsm__sync_reset(sr_b), .fsm__mst__ack_vld(ack),
        .fsm__mst__rd_data(rd_data), .timeout_evt(to_b)
    );

    assign pready   = sel ? pready_b  : pready_a;
    assign pslverr  = sel ? pslverr_b : pslverr_a;
    assign prdata   = sel ? prdata_b  : prdata_a;
    assign req_vld  = sel ? req_b     : req_a;
    assign rd_en    = sel ? rd_b      : rd_a;
    assign wr_en    = sel ? wr_b      : wr_a;
    assign maddr    = sel ? addr_b    : addr_a;
    assign mwdata   = sel ? wd_b      : wd_a;
    assign sync_rst = sel ? sr_b      : sr_a;
    assign tmo_evt  = sel ? to_b      : to_a;

    // One APB transfer; records what the DUT did, cycle 0 = setup.
    // dly: cycles from req_vld to ack (-1 = never); soft_at: cycle at
    // which soft_rst rises (-1 = never).
    task automatic run_xfer(input logic wr, input logic [63:0] a,
                            input logic [31:0] d, input int dly,
                            input logic [31:0] rdat, input int soft_at);
        int  cyc;
        logic done;
        nreq = 0; nrdy = 0; nsr = 0; nto = 0;
        rdy_cyc = -1; sr_first = -1; to_cyc = -1;
        rec_rd = 0; rec_wr = 0; rec_err = 0;
        rec_addr = '0; rec_wdata = '0; rec_prdata = '0;
        @(negedge clk);
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
        cyc = 0;
        done = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            penable = 1;
            ack = (dly >= 0) && (cyc == dly + 1);
            rd_data = ack ? rdat : (32'hBAD0_0000 + 32'(cyc));
            if (soft_at > 0 && cyc >= soft_at) soft_rst = 1;
            #1;
            if (req_vld) begin
                nreq++;
                rec_rd = rd_en; rec_wr = wr_en;
                rec_addr = maddr; rec_wdata = mwdata;
            end
            if (sync_rst) begin
                nsr++;
                if (sr_first < 0) sr_first = cyc;
            end
            if (tmo_evt) begin
                nto++;
                to_cyc = cyc;
            end
            if (pready) begin
                nrdy++;
                rdy_cyc = cyc;
                rec_prdata = prdata;
                rec_err = pslverr;
                done = 1;
            end
        end
        @(negedge clk);
        ack = 0; psel = 0; penable = 0;
        #1;
        post_rdy = pready;
    endtask

    task automatic test_reset();
        logic bad;
        rstn = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0;
        pwdata = '0; soft_rst = 0; ack = 0; rd_data = '0; sel = 0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if ({pready, pslverr, req_vld, rd_en, wr_en, sync_rst, tmo_evt}
            !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                {pready, pslverr, req_vld, rd_en, wr_en, sync_rst, tmo_evt});
        end
        n_chk++;
        if ({prdata, maddr, mwdata} !== 128'b0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h want 0 0 0",
                prdata, maddr, mwdata);
        end
        @(negedge clk);
        rstn = 1;
        // Stray acks while idle must not produce a response.
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            ack = 1;
            rd_data = 32'hFFFF_0000;
            #1;
            if (pready || req_vld) bad = 1;
        end
        @(negedge clk);
        ack = 0;
        #1;
        if (pready) bad = 1;
        n_chk++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ack_ignored: got response=%b want 0", bad);
        end
        // Async reset in the middle of a request.
        psel = 1; penable = 0; pwrite = 1; paddr = 64'h55;
        @(negedge clk);
        penable = 1;
        #1;
        n_chk++;
        if (req_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_req: got %b want 1", req_vld);
        end
        rstn = 0;
        #1;
        n_chk++;
        if ({req_vld, wr_en, maddr} !== 66'b0) begin
            n_fail++;
            $display("FAIL midrst_clear: got %b %b %h want 0 0 0",
                req_vld, wr_en, maddr);
        end
        psel = 0; penable = 0;
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        #1;
        n_chk++;
        if (pready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_resp: got %b want 0", pready);
        end
    endtask

    task automatic test_read_same_cycle();
        sel = 0;
        run_xfer(0, 64'h1000, 32'h0, 0, 32'hDEAD_BEEF, -1);
        n_chk++;
        if (nreq !== 1 || rec_rd !== 1 || rec_wr !== 0 ||
            rec_addr !== 64'h1000) begin
            n_fail++;
            $display("FAIL rd_req: got n=%0d rd=%b wr=%b a=%h want 1 1 0 1000",
                nreq, rec_rd, rec_wr, rec_addr);
        end
        n_chk++;
        if (rdy_cyc !== 2 || nrdy !== 1 || post_rdy !== 0) begin
            n_fail++;
            $display("FAIL rd_latency: got cyc=%0d n=%0d post=%b want 2 1 0",
                rdy_cyc, nrdy, post_rdy);
        end
        n_chk++;
        if (rec_prdata !== 32'hDEAD_BEEF || rec_err !== 0 || nsr !== 0) begin
            n_fail++;
            $display("FAIL rd_resp: got %h err=%b sr=%0d want deadbeef 0 0",
                rec_prdata, rec_err, nsr);
        end
    endtask

    task automatic test_write_late();
        sel = 0;
        run_xfer(1, 64'h40, 32'h1234, 5, 32'hCAFE_F00D, -1);
        n_chk++;
        if (nreq !== 1 || rec_wr !== 1 || rec_rd !== 0 ||
            rec_addr !== 64'h40 || rec_wdata !== 32'h1234) begin
            n_fail++;
            $display("FAIL wr_req: got n=%0d wr=%b rd=%b a=%h d=%h want 1 1 0 40 1234",
                nreq, rec_wr, rec_rd, rec_addr, rec_wdata);
        end
        n_chk++;
        if (nrdy !== 1 || rdy_cyc !== 7 || post_rdy !== 0) begin
            n_fail++;
            $display("FAIL wr_ready: got n=%0d cyc=%0d post=%b want 1 7 0",
                nrdy, rdy_cyc, post_rdy);
        end
        n_chk++;
        if (rec_prdata !== 32'h0 || rec_err !== 0 || nto !== 0) begin
            n_fail++;
            $display("FAIL wr_resp: got %h err=%b to=%0d want 0 0 0",
                rec_prdata, rec_err, nto);
        end
    endtask

    task automatic test_timeout();
        sel = 1;
        run_xfer(0, 64'h88, 32'h0, -1, 32'h0, -1);
        n_chk++;
        if (nsr !== 1 || nto !== 1 || to_cyc !== 5 || sr_first !== 5) begin
            n_fail++;
            $display("FAIL tmo_pulse: got sr=%0d to=%0d at %0d/%0d want 1 1 5 5",
                nsr, nto, to_cyc, sr_first);
        end
        n_chk++;
        if (nrdy !== 1 || rdy_cyc !== 6 || rec_err !== 1 ||
            rec_prdata !== 32'h0 || nreq !== 1) begin
            n_fail++;
            $display("FAIL tmo_resp: got n=%0d cyc=%0d err=%b d=%h req=%0d want 1 6 1 0 1",
                nrdy, rdy_cyc, rec_err, rec_prdata, nreq);
        end
        sel = 0;
    endtask

    task automatic test_ack_at_timeout();
        sel = 1;
        run_xfer(0, 64'h90, 32'h0, 4, 32'h0BAD_CAFE, -1);
        n_chk++;
        if (nsr !== 0 || nto !== 0) begin
            n_fail++;
            $display("FAIL race_pulse: got sr=%0d to=%0d want 0 0", nsr, nto);
        end
        n_chk++;
        if (rec_err !== 0 || rec_prdata !== 32'h0BAD_CAFE || rdy_cyc !== 6) begin
            n_fail++;
            $display("FAIL race_resp: got err=%b d=%h cyc=%0d want 0 0badcafe 6",
                rec_err, rec_prdata, rdy_cyc);
        end
        sel = 0;
    endtask

    task automatic test_soft_rst();
        logic bad;
        sel = 0;
        run_xfer(0, 64'h70, 32'h0, -1, 32'h0, 3);
        n_chk++;
        if (sr_first !== 3 || rec_err !== 1 || rec_prdata !== 32'h0 ||
            rdy_cyc !== 4 || nto !== 0) begin
            n_fail++;
            $display("FAIL soft_abort: got sr@%0d err=%b d=%h cyc=%0d to=%0d want 3 1 0 4 0",
                sr_first, rec_err, rec_prdata, rdy_cyc, nto);
        end
        @(negedge clk);
        psel = 1; penable = 0; pwrite = 0; paddr = 64'h80;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (req_vld !== 1'b0 || sync_rst !== 1'b1) bad = 1;
        end
        n_chk++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL soft_holdoff: got violation=%b want 0", bad);
        end
        @(negedge clk);
        soft_rst = 0;
        @(negedge clk);
        #1;
        n_chk++;
        if (req_vld !== 1 || rd_en !== 1 || maddr !== 64'h80) begin
            n_fail++;
            $display("FAIL soft_release: got v=%b rd=%b a=%h want 1 1 80",
                req_vld, rd_en, maddr);
        end
        penable = 1; ack = 1; rd_data = 32'h5A5A_5A5A;
        @(negedge clk);
        ack = 0;
        #1;
        n_chk++;
        if (pready !== 1 || prdata !== 32'h5A5A_5A5A || pslverr !== 0) begin
            n_fail++;
            $display("FAIL soft_after: got r=%b d=%h e=%b want 1 5a5a5a5a 0",
                pready, prdata, pslverr);
        end
        @(negedge clk);
        psel = 0; penable = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ref_mem [16];
        logic [31:0] slv_mem [16];
        int          total_req, idx, dly;
        logic        wr, bad;
        logic [63:0] a;
        logic [31:0] d, exp_d;
        sel = 0;
        total_req = 0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'h0101_0101 * 32'(i) + 32'h7;
            slv_mem[i] = ref_mem[i];
        end
        for (int i = 0; i < 10; i++) begin
            wr  = 1'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 15));
            dly = int'($urandom_range(0, 3));
            d   = $urandom;
            a   = 64'h2000 + 64'(idx * 4);
            exp_d = wr ? 32'h0 : ref_mem[idx];
            if (wr) ref_mem[idx] = d;
            run_xfer(wr, a, d, dly, slv_mem[idx], -1);
            total_req += nreq;
            if (rec_wr && nreq == 1) slv_mem[rec_addr[5:2]] = rec_wdata;
            bad = (nrdy != 1) || (rec_err !== 0) || (rec_prdata !== exp_d) ||
                  (rec_addr !== a) || (rec_wr !== wr) ||
                  (wr && rec_wdata !== d);
            n_chk++;
            if (bad) begin
                n_fail++;
                $display("FAIL b2b_%0d: got rdy=%0d e=%b d=%h a=%h w=%b wd=%h want 1 0 %h %h %b %h",
                    i, nrdy, rec_err, rec_prdata, rec_addr, rec_wr, rec_wdata,
                    exp_d, a, wr, d);
            end
        end
        n_chk++;
        if (total_req !== 10) begin
            n_fail++;
            $display("FAIL b2b_req_count: got %0d want 10", total_req);
        end
    endtask

    initial begin
        test_reset();
        test_read_same_cycle();
        test_write_late();
        test_timeout();
        test_ack_at_timeout();
        test_soft_rst();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
            n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
